// File: rtl/mem_unit.sv
// mem_unit: unified instruction/data word memory, request/response handshake, programmable wait states.
// Latency: accept edge to rsp_valid = WAIT_CYCLES+1 cycles; one request every WAIT_CYCLES+2 cycles.
// Backpressure: req_ready is low while a request is in flight (WAIT/RESP); nothing is accepted in RESP.
// Build option: define MEM_BYTE_STROBE_EN to add the req_be byte-lane write enables.
module mem_unit #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
`ifdef MEM_BYTE_STROBE_EN
   input  logic [3:0]  req_be,
`endif
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        misalign_err,
   output logic        busy
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          wcnt_q, wcnt_d;
   logic                write_q, write_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic                mis_q, mis_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [3:0]          be_q, be_d;
   logic [31:0]         rdata_q, rdata_d;

   // Access performed on the edge entering RESP; with zero wait states the
   // incoming request fields are used directly since nothing is captured yet.
   logic                acc_go;
   logic                acc_write;
   logic [ADDR_W-1:0]   acc_idx;
   logic                acc_mis;
   logic [31:0]         acc_wdata;
   logic [3:0]          acc_be;
   logic                mem_we;

   logic [31:0]         mem [DEPTH];
   logic [3:0]          in_be;

   // Upper address bits are deliberately ignored: the word index wraps modulo depth.
   logic                unused_addr_bits;
   assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

`ifdef MEM_BYTE_STROBE_EN
   assign in_be = req_be;
`else
   assign in_be = 4'hF;
`endif

   // Next-state, request capture and access decode
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      write_d   = write_q;
      idx_d     = idx_q;
      mis_d     = mis_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      rdata_d   = rdata_q;
      acc_go    = 1'b0;
      acc_write = write_q;
      acc_idx   = idx_q;
      acc_mis   = mis_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               idx_d   = req_addr[ADDR_W+1:2];
               mis_d   = |req_addr[1:0];
               wdata_d = req_wdata;
               be_d    = in_be;
               wcnt_d  = 4'(WAIT_CYCLES);
               if (WAIT_CYCLES == 0) begin
                  state_d   = S_RESP;
                  acc_go    = 1'b1;
                  acc_write = req_write;
                  acc_idx   = req_addr[ADDR_W+1:2];
                  acc_mis   = |req_addr[1:0];
                  acc_wdata = req_wdata;
                  acc_be    = in_be;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            wcnt_d = wcnt_q - 4'd1;
            // A zero count cannot occur here; treated as done so the FSM never stalls.
            if (wcnt_q == 4'd1 || wcnt_q == 4'd0) begin
               state_d = S_RESP;
               acc_go  = 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Misaligned requests return zero and never touch the array; writes leave rdata alone.
      if (acc_go) begin
         if (acc_mis) begin
            rdata_d = '0;
         end else if (!acc_write) begin
            rdata_d = mem[acc_idx];
         end
      end
      // Gated by reset so a request presented while reset is held cannot write.
      mem_we = acc_go & acc_write & ~acc_mis & reset;
   end

   // State and captured-request registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         write_q <= 1'b0;
         idx_q   <= '0;
         mis_q   <= 1'b0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         write_q <= write_d;
         idx_q   <= idx_d;
         mis_q   <= mis_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
      end
   end

   // Word array with per-lane write; no reset so contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) begin
               mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

   assign req_ready    = (state_q == S_IDLE);
   assign busy         = (state_q != S_IDLE);
   assign rsp_valid    = (state_q == S_RESP);
   assign misalign_err = rsp_valid & mis_q;
   assign rsp_rdata    = rdata_q;

endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: directed test of mem_unit with WAIT_CYCLES=2 and WAIT_CYCLES=0 instances.
// Requests driven on the falling edge, outputs sampled on the falling edge.
// Build option: MEM_BYTE_STROBE_EN enables the byte-lane cases.
module tb_mem_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid2, valid0;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;

   logic        ready2, rsp2, merr2, busy2;
   logic [31:0] rdata2;
   logic        ready0, rsp0, merr0, busy0;
   logic [31:0] rdata0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_unit #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut2 (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (valid2),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
`ifdef MEM_BYTE_STROBE_EN
      .req_be       (req_be),
`endif
      .req_ready    (ready2),
      .rsp_valid    (rsp2),
      .rsp_rdata    (rdata2),
      .misalign_err (merr2),
      .busy         (busy2)
   );

   mem_unit #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (valid0),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
`ifdef MEM_BYTE_STROBE_EN
      .req_be       (req_be),
`endif
      .req_ready    (ready0),
      .rsp_valid    (rsp0),
      .rsp_rdata    (rdata0),
      .misalign_err (merr0),
      .busy         (busy0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One complete request on the selected instance; returns response data and latency.
   task automatic access(input bit on0, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be,
                         output logic [31:0] rdata, output logic merr, output int lat);
      int guard;
      @(negedge clk);
      req_write = wr;
      req_addr  = addr;
      req_wdata = data;
      req_be    = be;
      guard = 0;
      while (!(on0 ? ready0 : ready2) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (on0) valid0 = 1'b1;
      else     valid2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid0    = 1'b0;
      valid2    = 1'b0;
      // Scramble inputs after accept: the captured request must be unaffected.
      req_addr  = 32'hFFFF_FFFC;
      req_wdata = ~data;
      req_write = ~wr;
      req_be    = ~be;
      lat = 1;
      while (!(on0 ? rsp0 : rsp2) && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      rdata = on0 ? rdata0 : rdata2;
      merr  = on0 ? merr0 : merr2;
   endtask

   initial begin
      logic [31:0] rd;
      logic        me;
      int          lat;
      int          pulses;
      logic [5:0]  rdy_vec, rsp_vec;

      reset = 1'b0; valid2 = 1'b0; valid0 = 1'b0;
      req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = 4'hF;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ready", {31'd0, ready2}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp2}, 32'd0);
      check("rst_rdata", rdata2, 32'd0);
      check("rst_busy", {31'd0, busy2}, 32'd0);
      check("rst_merr", {31'd0, merr2}, 32'd0);
      check("rst_ready0", {31'd0, ready0}, 32'd1);
      reset = 1'b1;

      // Seed word 0x10, then drop a write to it with a reset pulse mid-WAIT
      access(1'b0, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF, rd, me, lat);
      check("wr10_lat", lat, 32'd3);
      @(negedge clk);
      req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
      valid2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid2 = 1'b0;
      check("wait_busy", {31'd0, busy2}, 32'd1);
      check("wait_ready", {31'd0, ready2}, 32'd0);
      reset = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy2}, 32'd0);
      check("midrst_ready", {31'd0, ready2}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         if (rsp2) pulses++;
      end
      check("midrst_no_rsp", pulses, 32'd0);
      access(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, rd, me, lat);
      check("rd10_prior", rd, 32'hA5A5_0001);

      // Write / read 0x40 with two wait states
      access(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, rd, me, lat);
      check("wr40_lat", lat, 32'd3);
      check("wr40_merr", {31'd0, me}, 32'd0);
      check("wr40_rdata_kept", rd, 32'hA5A5_0001);
      access(1'b0, 1'b0, 32'h40, 32'h0, 4'hF, rd, me, lat);
      check("rd40_lat", lat, 32'd3);
      check("rd40_data", rd, 32'hDEAD_BEEF);
      check("rd40_merr", {31'd0, me}, 32'd0);
      repeat (3) @(negedge clk);
      check("rd40_held", rdata2, 32'hDEAD_BEEF);
      check("rd40_merr_idle", {31'd0, merr2}, 32'd0);

      // Misaligned read and write
      access(1'b0, 1'b0, 32'h42, 32'h0, 4'hF, rd, me, lat);
      check("rd42_data", rd, 32'h0);
      check("rd42_merr", {31'd0, me}, 32'd1);
      access(1'b0, 1'b1, 32'h41, 32'h0BAD_0BAD, 4'hF, rd, me, lat);
      check("wr41_merr", {31'd0, me}, 32'd1);
      access(1'b0, 1'b0, 32'h40, 32'h0, 4'hF, rd, me, lat);
      check("rd40_after41", rd, 32'hDEAD_BEEF);

      // Address wrap: 0x400 aliases word 0 with ADDR_W=8
      access(1'b0, 1'b1, 32'h400, 32'h1234_5678, 4'hF, rd, me, lat);
      access(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, rd, me, lat);
      check("wrap_rd0", rd, 32'h1234_5678);

`ifdef MEM_BYTE_STROBE_EN
      access(1'b0, 1'b1, 32'h40, 32'h1122_3344, 4'b0101, rd, me, lat);
      access(1'b0, 1'b0, 32'h40, 32'h0, 4'hF, rd, me, lat);
      check("be0101_rd", rd, 32'hDE22_BE44);
      access(1'b0, 1'b1, 32'h40, 32'h5566_7788, 4'b0000, rd, me, lat);
      check("be0000_ack_lat", lat, 32'd3);
      access(1'b0, 1'b0, 32'h40, 32'h0, 4'hF, rd, me, lat);
      check("be0000_rd", rd, 32'hDE22_BE44);
`endif

      // Zero wait states: single write, then back-to-back reads with valid held
      access(1'b1, 1'b1, 32'h8, 32'hCAFE_F00D, 4'hF, rd, me, lat);
      check("w0_wr_lat", lat, 32'd1);
      @(negedge clk);
      req_write = 1'b0; req_addr = 32'h8; req_be = 4'hF;
      valid0 = 1'b1;
      rdy_vec = '0;
      rsp_vec = '0;
      for (int n = 0; n < 6; n++) begin
         if (n > 0) @(negedge clk);
         rdy_vec[n] = ready0;
         rsp_vec[n] = rsp0;
      end
      valid0 = 1'b0;
      check("w0_ready_pattern", {26'd0, rdy_vec}, 32'h15);
      check("w0_rsp_pattern", {26'd0, rsp_vec}, 32'h2A);
      check("w0_rd_data", rdata0, 32'hCAFE_F00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
